// File: rtl/ovi_issue_queue_pkg.sv
// Shared types and defaults for the OVI issue queue: entry layout and the
// bridge-facing issue/completion bus structures.
package ovi_issue_queue_pkg;

    localparam int OVI_IQ_DEPTH           = 4;
    localparam int OVI_IQ_MAX_OUTSTANDING = 4;
    localparam int OVI_VL_WIDTH           = 15;
    localparam int OVI_SEW_WIDTH          = 3;

    typedef struct packed {
        logic [31:0]              instr;
        logic [OVI_VL_WIDTH-1:0]  vl;
        logic [OVI_SEW_WIDTH-1:0] sew;
    } iq_entry_t;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              instr;
        logic [OVI_VL_WIDTH-1:0]  vl;
        logic [OVI_SEW_WIDTH-1:0] sew;
    } core_issue_bus_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } core_completed_bus_t;

endpackage

// File: rtl/ovi_issue_queue_if.sv
// Decode push port plus bridge issue/completion handshake of the issue queue.
interface ovi_issue_queue_if import ovi_issue_queue_pkg::*; ();

    logic                     dec_valid;
    logic                     dec_ready;
    logic [31:0]              dec_instr;
    logic [OVI_VL_WIDTH-1:0]  dec_vl;
    logic [OVI_SEW_WIDTH-1:0] dec_sew;
    core_issue_bus_t          core_issue;
    logic                     core_halt;
    core_completed_bus_t      core_completed;

    modport master (
        output dec_valid, dec_instr, dec_vl, dec_sew, core_halt, core_completed,
        input  dec_ready, core_issue
    );

    modport slave (
        input  dec_valid, dec_instr, dec_vl, dec_sew, core_halt, core_completed,
        output dec_ready, core_issue
    );

endinterface

// File: rtl/ovi_sync_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module ovi_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers and count; flush collapses the read pointer onto the write pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ovi_issue_queue.sv
// In-order issue queue in front of the OVI bridge: buffers decoded vector
// instructions, gates issue on outstanding credit, registers completions.
module ovi_issue_queue import ovi_issue_queue_pkg::*; #(
    parameter  int DEPTH           = OVI_IQ_DEPTH,
    parameter  int MAX_OUTSTANDING = OVI_IQ_MAX_OUTSTANDING,
    parameter  int VL_WIDTH        = OVI_VL_WIDTH,
    parameter  int SEW_WIDTH       = OVI_SEW_WIDTH,
    localparam int CNT_W           = $clog2(DEPTH + 1),
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    ovi_issue_queue_if.slave   io_bus,
    input  logic               i_flush,
    output logic               o_wb_valid,
    output logic [63:0]        o_wb_data,
    output logic [CNT_W-1:0]   o_occupancy,
    output logic               o_vpu_idle,
    output logic               o_err_underflow
);

    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);

    iq_entry_t        w_din;
    iq_entry_t        w_head;
    core_issue_bus_t  w_issue;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_issue_valid;
    logic             w_comp_valid;
    logic [OUT_W-1:0] r_outstanding;
    logic             r_wb_valid;
    logic [63:0]      r_wb_data;
    logic             r_err_underflow;

    assign io_bus.dec_ready = !i_flush && !w_full;
    assign w_push           = io_bus.dec_valid && io_bus.dec_ready;
    assign w_issue_valid    = !w_empty && (r_outstanding < MAX_OUT_C) && !i_flush;
    assign w_pop            = w_issue_valid && !io_bus.core_halt;
    assign w_comp_valid     = io_bus.core_completed.valid;

    // Pack the decode fields into a queue entry.
    always_comb begin
        w_din       = '0;
        w_din.instr = io_bus.dec_instr;
        w_din.vl    = io_bus.dec_vl[VL_WIDTH-1:0];
        w_din.sew   = io_bus.dec_sew[SEW_WIDTH-1:0];
    end

    ovi_sync_fifo #(
        .WIDTH ($bits(iq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_flush),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Present the head to the bridge; stale storage is hidden when empty.
    always_comb begin
        w_issue       = '0;
        w_issue.valid = w_issue_valid;
        if (!w_empty) begin
            w_issue.instr = w_head.instr;
            w_issue.vl    = w_head.vl;
            w_issue.sew   = w_head.sew;
        end else begin
            w_issue.instr = 32'd0;
            w_issue.vl    = '0;
            w_issue.sew   = '0;
        end
    end

    assign io_bus.core_issue = w_issue;

    // Instructions in the VPU; a completion with nothing outstanding saturates at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_outstanding <= '0;
        end else begin
            case ({w_pop, w_comp_valid})
                2'b10: r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01: begin
                    if (r_outstanding != '0) begin
                        r_outstanding <= r_outstanding - OUT_W'(1);
                    end else begin
                        r_outstanding <= r_outstanding;
                    end
                end
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_underflow <= 1'b0;
        end else if (w_comp_valid && (r_outstanding == '0)) begin
            r_err_underflow <= 1'b1;
        end else begin
            r_err_underflow <= r_err_underflow;
        end
    end

    // Writeback stage; data holds its last value between strobes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= 64'd0;
        end else begin
            r_wb_valid <= w_comp_valid;
            if (w_comp_valid) begin
                r_wb_data <= io_bus.core_completed.data;
            end else begin
                r_wb_data <= r_wb_data;
            end
        end
    end

    assign o_wb_valid      = r_wb_valid;
    assign o_wb_data       = r_wb_data;
    assign o_err_underflow = r_err_underflow;
    assign o_occupancy     = w_count;
    assign o_vpu_idle      = (w_count == '0) && (r_outstanding == '0);

endmodule
